bus_interface: RTL



---
 rtl/bus_interface.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bus_interface.sv
// Host-bus front end: synchronizes the async 8-bit bus and issues one read/write strobe per chip-select access.
// Optional feature macro BUS_ACK_EN enables bus_ack_o; when undefined the port is tied low.
module bus_interface #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       bus_cs_n_i,
  input  logic       bus_rd_nwr_i,
  input  logic [3:0] bus_reg_num_i,
  input  logic       bus_bytesel_i,
  input  logic [7:0] bus_data_i,
  output logic [7:0] bus_data_o,
  output logic       bus_out_ena_o,
  output logic       write_strobe_o,
  output logic       read_strobe_o,
  output logic [3:0] reg_num_o,
  output logic       bytesel_o,
  output logic [7:0] data_o,
  input  logic [7:0] read_data_i,
  output logic       bus_ack_o
);

  typedef enum logic [1:0] {IDLE, STROBE, RDWAIT, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   cs_s;
  logic                   armed_q, armed_d;

  logic                   rd_nwr_in_q, rd_nwr_in_d;
  logic [3:0]             reg_num_in_q, reg_num_in_d;
  logic                   bytesel_in_q, bytesel_in_d;
  logic [7:0]             data_in_q, data_in_d;

  logic                   rd_nwr_q, rd_nwr_d;
  logic [3:0]             reg_num_q, reg_num_d;
  logic                   bytesel_q, bytesel_d;
  logic [7:0]             data_q, data_d;
  logic [7:0]             bus_data_q, bus_data_d;
  logic                   bus_out_ena_q, bus_out_ena_d;
  logic                   write_strobe_q, write_strobe_d;
  logic                   read_strobe_q, read_strobe_d;

  assign cs_s = cs_sync_q[SYNC_STAGES-1];

  always_comb begin
    cs_sync_d      = {cs_sync_q[SYNC_STAGES-2:0], bus_cs_n_i};
    sync_vld_d     = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    rd_nwr_in_d    = bus_rd_nwr_i;
    reg_num_in_d   = bus_reg_num_i;
    bytesel_in_d   = bus_bytesel_i;
    data_in_d      = bus_data_i;
    state_d        = state_q;
    armed_d        = armed_q;
    rd_nwr_d       = rd_nwr_q;
    reg_num_d      = reg_num_q;
    bytesel_d      = bytesel_q;
    data_d         = data_q;
    bus_data_d     = bus_data_q;
    bus_out_ena_d  = bus_out_ena_q;
    write_strobe_d = 1'b0;
    read_strobe_d  = 1'b0;

    // cs_s only counts as "high" once the chain holds real pin samples, not its reset fill
    if (cs_s && (&sync_vld_q)) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (!cs_s && armed_q) begin
          armed_d        = 1'b0;
          rd_nwr_d       = rd_nwr_in_q;
          reg_num_d      = reg_num_in_q;
          bytesel_d      = bytesel_in_q;
          data_d         = data_in_q;
          write_strobe_d = ~rd_nwr_in_q;
          read_strobe_d  = rd_nwr_in_q;
          state_d        = STROBE;
        end
      end
      STROBE: state_d = rd_nwr_q ? RDWAIT : HOLD;
      RDWAIT: begin
        bus_data_d    = read_data_i;
        bus_out_ena_d = 1'b1;
        state_d       = HOLD;
      end
      HOLD: begin
        if (cs_s) begin
          bus_out_ena_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      cs_sync_q      <= '1;
      sync_vld_q     <= '0;
      armed_q        <= 1'b0;
      rd_nwr_in_q    <= 1'b0;
      reg_num_in_q   <= 4'h0;
      bytesel_in_q   <= 1'b0;
      data_in_q      <= 8'h00;
      rd_nwr_q       <= 1'b0;
      reg_num_q      <= 4'h0;
      bytesel_q      <= 1'b0;
      data_q         <= 8'h00;
      bus_data_q     <= 8'h00;
      bus_out_ena_q  <= 1'b0;
      write_strobe_q <= 1'b0;
      read_strobe_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cs_sync_q      <= cs_sync_d;
      sync_vld_q     <= sync_vld_d;
      armed_q        <= armed_d;
      rd_nwr_in_q    <= rd_nwr_in_d;
      reg_num_in_q   <= reg_num_in_d;
      bytesel_in_q   <= bytesel_in_d;
      data_in_q      <= data_in_d;
      rd_nwr_q       <= rd_nwr_d;
      reg_num_q      <= reg_num_d;
      bytesel_q      <= bytesel_d;
      data_q         <= data_d;
      bus_data_q     <= bus_data_d;
      bus_out_ena_q  <= bus_out_ena_d;
      write_strobe_q <= write_strobe_d;
      read_strobe_q  <= read_strobe_d;
    end
  end

  assign bus_data_o     = bus_data_q;
  assign bus_out_ena_o  = bus_out_ena_q;
  assign write_strobe_o = write_strobe_q;
  assign read_strobe_o  = read_strobe_q;
  assign reg_num_o      = reg_num_q;
  assign bytesel_o      = bytesel_q;
  assign data_o         = data_q;

`ifdef BUS_ACK_EN
  logic ack_q, ack_d;

  always_comb begin
    ack_d = ack_q;
    if (state_q == STROBE && !rd_nwr_q) ack_d = 1'b1;
    else if (state_q == RDWAIT) ack_d = 1'b1;
    else if (state_q == HOLD && cs_s) ack_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) ack_q <= 1'b0;
    else            ack_q <= ack_d;
  end

  assign bus_ack_o = ack_q;
`else
  assign bus_ack_o = 1'b0;
`endif

endmodule
